// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read data-memory port between
// the CPU memory stage and a DMA/loader requester, using a req/ack handshake.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic                  cpuWrite,
  input  logic                  cpuByte,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWrData,
  output logic                  cpuAck,
  output logic [DATA_WIDTH-1:0] cpuRdData,
  output logic                  cpuStall,
  input  logic                  dmaReq,
  input  logic                  dmaWrite,
  input  logic                  dmaByte,
  input  logic [ADDR_WIDTH-1:0] dmaAddr,
  input  logic [DATA_WIDTH-1:0] dmaWrData,
  output logic                  dmaAck,
  output logic [DATA_WIDTH-1:0] dmaRdData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWrData,
  output logic                  memWrite,
  output logic                  memStoreByte,
  input  logic [DATA_WIDTH-1:0] memRdData
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  write;
    logic                  is_byte;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_e                state_q;
  owner_e                owner_q;
  owner_e                last_grant_q;
  acc_t                  acc_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rd_q;
  logic [DATA_WIDTH-1:0] dma_rd_q;

  logic                  cpu_elig_d;
  logic                  dma_elig_d;
  logic                  grant_d;
  owner_e                grant_owner_d;
  acc_t                  acc_d;
  logic [DATA_WIDTH-1:0] load_data_d;

  // The port acked in RESP still shows its old request, so it sits out that cycle.
  always_comb begin
    cpu_elig_d = cpuReq;
    dma_elig_d = dmaReq;
    if (state_q == S_RESP) begin
      if (owner_q == OWN_CPU) cpu_elig_d = 1'b0;
      else                    dma_elig_d = 1'b0;
    end
  end

  // Single requester wins outright; a tie goes to the port not granted last.
  always_comb begin
    grant_d       = 1'b0;
    grant_owner_d = OWN_CPU;
    if (state_q != S_ACC) begin
      grant_d = cpu_elig_d | dma_elig_d;
      if (cpu_elig_d && dma_elig_d) begin
        grant_owner_d = (last_grant_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (dma_elig_d) begin
        grant_owner_d = OWN_DMA;
      end
    end
  end

  always_comb begin
    acc_d = '0;
    if (grant_owner_d == OWN_CPU) begin
      acc_d.write   = cpuWrite;
      acc_d.is_byte = cpuByte;
      acc_d.addr    = cpuAddr;
      acc_d.wdata   = cpuWrData;
    end else begin
      acc_d.write   = dmaWrite;
      acc_d.is_byte = dmaByte;
      acc_d.addr    = dmaAddr;
      acc_d.wdata   = dmaWrData;
    end
  end

  always_comb begin
    load_data_d = memRdData;
    if (acc_q.is_byte) load_data_d = DATA_WIDTH'(memRdData[BYTE_W-1:0]);
  end

  // Arbitration FSM; acks and read data are registered at the ACC-ending edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DMA;
      acc_q        <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rd_q     <= '0;
      dma_rd_q     <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (grant_d) begin
            state_q      <= S_ACC;
            owner_q      <= grant_owner_d;
            last_grant_q <= grant_owner_d;
            acc_q        <= acc_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACC: begin
          state_q <= S_RESP;
          if (owner_q == OWN_CPU) begin
            cpu_ack_q <= 1'b1;
            if (!acc_q.write) cpu_rd_q <= load_data_d;
          end else begin
            dma_ack_q <= 1'b1;
            if (!acc_q.write) dma_rd_q <= load_data_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpuAck       = cpu_ack_q;
  assign dmaAck       = dma_ack_q;
  assign cpuRdData    = cpu_rd_q;
  assign dmaRdData    = dma_rd_q;
  assign cpuStall     = cpuReq & ~cpu_ack_q;
  assign memAddr      = acc_q.addr;
  assign memWrData    = acc_q.wdata;
  // Reset low during ACC must not let the dropped access reach memory.
  assign memWrite     = (state_q == S_ACC) & acc_q.write & reset;
  assign memStoreByte = (state_q == S_ACC) & acc_q.is_byte;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data-memory port of the Memory stage between the CPU memory stage and a DMA/loader requester (program loader, GPIO mirror). It owns the memory control lines (address, write data, write strobe, store-byte), serialises requests with round-robin fairness and a req/ack handshake, registers read data with load-byte zero-extension, and stalls the CPU while its access is pending.

## Interface
- ADDR_WIDTH, 32, byte address width to memory.
- DATA_WIDTH, 32, data word width; byte lane is bits [7:0].
- clock  in  1  single system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clock.
- cpuReq / dmaReq  in  1  request, held high with fields stable until ack.
- cpuWrite / dmaWrite  in  1  1 = store, 0 = load.
- cpuByte / dmaByte  in  1  byte access (store low byte / load zero-extended byte).
- cpuAddr / dmaAddr  in  ADDR_WIDTH  access address.
- cpuWrData / dmaWrData  in  DATA_WIDTH  store data.
- cpuAck / dmaAck  out  1  one-cycle completion pulse.
- cpuRdData / dmaRdData  out  DATA_WIDTH  registered load data, valid in ack cycle, held until next load by same port.
- cpuStall  out  1  cpuReq & ~cpuAck (combinational).
- memAddr  out  ADDR_WIDTH  memory address.
- memWrData  out  DATA_WIDTH  memory write data.
- memWrite  out  1  memory write strobe.
- memStoreByte  out  1  byte-store qualifier to memory.
- memRdData  in  DATA_WIDTH  asynchronous-read memory data for memAddr.

## Operation
- States: IDLE, ACC, RESP. Registers: owner (CPU/DMA), lastGrant, latched addr/wrData/write/byte.
- IDLE: if any eligible req, grant and go ACC, latching the winner's fields at the edge; else stay.
- Arbitration: single requester wins; both requesting -> the one not equal to lastGrant. lastGrant updated on every grant.
- ACC (exactly 1 cycle): memAddr/memWrData/memStoreByte from latched fields; memWrite = latched write. Memory write commits at the ACC-ending edge; on a load, owner's rdData captures memRdData (byte: {zeros, memRdData[7:0]}) at that same edge; stores leave rdData unchanged. Next state RESP.
- RESP: owner's ack = 1. The acked port is ineligible this cycle (its req is still the old request). If the other port requests, grant it and go ACC; else IDLE.
- Outside ACC: memWrite = 0, memStoreByte = 0, memAddr/memWrData hold last latched values.
- Requester may present a new request the cycle after its ack; it is arbitrated from then on.
- Dropping req before ack is illegal; the arbiter completes the latched access regardless.

## Timing
- Reset (reset = 0 at an edge): state IDLE, lastGrant = DMA (CPU wins first tie), both acks 0, both rdData 0, latched fields 0, memWrite 0.
- memWrite is additionally gated by reset (memWrite = ACC & write & reset) so an access in ACC when reset is low does not write; the transaction is dropped, no ack issued.
- Latency: req high in IDLE at cycle n -> ACC at n+1 -> ack and rdData at n+2.
- Throughput: alternating requesters sustain one access per 2 cycles (RESP -> ACC); one port alone: one access per 3 cycles.
- Fairness: with both reqs continuously high, grants strictly alternate; maximum wait for either port is one foreign access (4 cycles to ack).
- Address/data are passed unmodified; no alignment checking. ack never asserted to both ports in the same cycle.

## Test plan
- Reset: hold reset = 0 two cycles with both reqs high -> no acks, memWrite 0, rdData 0; release -> CPU granted first.
- CPU store then load: cpuWrite=1, addr 0x8, data 0x000F938A -> memWrite high one cycle, cpuAck at n+2; load byte addr 0x8 -> cpuRdData = 0x0000008A; word load -> 0x000F938A.
- Byte store: DMA store byte addr 0x4 data 0xABCD -> memStoreByte = 1 in ACC only, dmaAck at n+2.
- Contention: both req continuously from reset release, addrs 0x10/0x20 -> grant order CPU, DMA, CPU, DMA; acks every 2 cycles, never simultaneous; cpuStall high except in cpuAck cycles.
- Reset mid-ACC: pull reset low during a DMA store to addr 0x30 of 0x55 -> memWrite 0, no dmaAck, later load of 0x30 returns prior value (0).
- Single port back-to-back: CPU issues new load the cycle after each ack -> ack spacing exactly 3 cycles, rdData updates only at ack.
